ex_mem_wb_pipe: RTL and testbench

EX_MEM_WB_PIPE -- requirements
Module: ex_mem_wb_pipe

---
 rtl/ex_mem_wb_pipe.sv | 180 ++++++++++++++++++
 tb/tb_ex_mem_wb_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM/WB back end of a 5-stage RV32 pipeline.
// This block contains the MEM pipeline register, the data-memory handshake FSM,
// load/store lane formatting, the WB pipeline register and a saturating stall counter.
module ex_mem_wb_pipe #(
   parameter int STALL_CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ex_valid,
   input  logic [4:0]             ex_rd,
   input  logic                   ex_reg_file_wr,
   input  logic                   ex_mem_rd,
   input  logic                   ex_mem_wr,
   input  logic [2:0]             ex_funct3,
   input  logic [31:0]            ex_alu_result,
   input  logic [31:0]            ex_store_data,
   input  logic                   dmem_ready,
   input  logic [31:0]            dmem_rdata,
   output logic                   dmem_req,
   output logic                   dmem_we,
   output logic [31:0]            dmem_addr,
   output logic [31:0]            dmem_wdata,
   output logic [3:0]             dmem_be,
   output logic                   mem_stall,
   output logic [4:0]             rd_mem,
   output logic                   reg_file_wr_mem,
   output logic [31:0]            mem_fwd_data,
   output logic                   mem_is_load,
   output logic [4:0]             rd_wb,
   output logic                   reg_file_wr_wb,
   output logic [31:0]            wb_data,
   output logic                   misaligned,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   typedef enum logic {S_IDLE, S_WAIT} mem_state_t;

   mem_state_t  state, state_next;

   logic        mem_valid;
   logic [4:0]  mem_rd;
   logic        mem_reg_file_wr;
   logic        mem_mem_rd;
   logic        mem_mem_wr;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_alu_result;
   logic [31:0] mem_store_data;

   logic        mem_access;
   logic        addr_bad;
   logic        access_go;
   logic [1:0]  size;
   logic [1:0]  addr_lo;
   logic [3:0]  be_raw;
   logic [31:0] rdata_shifted;
   logic [31:0] load_data;

   // MEM pipeline register: take the EX instruction unless memory is stalling
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_valid       <= 1'b0;
         mem_rd          <= 5'd0;
         mem_reg_file_wr <= 1'b0;
         mem_mem_rd      <= 1'b0;
         mem_mem_wr      <= 1'b0;
         mem_funct3      <= 3'd0;
         mem_alu_result  <= 32'd0;
         mem_store_data  <= 32'd0;
      end else if (!mem_stall) begin
         mem_valid       <= ex_valid;
         mem_rd          <= ex_rd;
         mem_reg_file_wr <= ex_reg_file_wr;
         mem_mem_rd      <= ex_mem_rd;
         mem_mem_wr      <= ex_mem_wr;
         mem_funct3      <= ex_funct3;
         mem_alu_result  <= ex_alu_result;
         mem_store_data  <= ex_store_data;
      end
   end

   assign size       = mem_funct3[1:0];
   assign addr_lo    = mem_alu_result[1:0];
   assign mem_access = mem_valid & (mem_mem_rd | mem_mem_wr);
   assign addr_bad   = ((size == 2'b01) & addr_lo[0]) | ((size == 2'b10) & (addr_lo != 2'b00));
   assign access_go  = mem_access & ~addr_bad;
   assign misaligned = mem_access & addr_bad;

   assign rd_mem          = mem_rd;
   assign reg_file_wr_mem = mem_valid & mem_reg_file_wr;
   assign mem_fwd_data    = mem_alu_result;
   assign mem_is_load     = mem_valid & mem_mem_rd;

   // Memory handshake state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Request generation and IDLE/WAIT transitions; the held MEM register keeps the request stable in WAIT
   always_comb begin
      state_next = state;
      dmem_req   = 1'b0;
      case (state)
         S_IDLE: begin
            if (access_go) begin
               dmem_req = 1'b1;
               if (!dmem_ready) state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            dmem_req = 1'b1;
            if (dmem_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign mem_stall = dmem_req & ~dmem_ready;
   assign dmem_we   = dmem_req & mem_mem_wr;
   assign dmem_addr = {mem_alu_result[31:2], 2'b00};
   assign dmem_be   = dmem_req ? be_raw : 4'b0000;

   // Byte-lane enables and replicated store data by access size
   always_comb begin
      be_raw     = 4'b0000;
      dmem_wdata = mem_store_data;
      case (size)
         2'b00: begin
            be_raw     = 4'b0001 << addr_lo;
            dmem_wdata = {4{mem_store_data[7:0]}};
         end
         2'b01: begin
            be_raw     = 4'b0011 << addr_lo;
            dmem_wdata = {2{mem_store_data[15:0]}};
         end
         2'b10: begin
            be_raw     = 4'b1111;
         end
         default: begin
            be_raw     = 4'b0000;
         end
      endcase
   end

   assign rdata_shifted = dmem_rdata >> {addr_lo, 3'b000};

   // Load lane select then sign or zero extension (funct3[2] set means unsigned)
   always_comb begin
      load_data = dmem_rdata;
      case (size)
         2'b00:   load_data = {{24{~mem_funct3[2] & rdata_shifted[7]}}, rdata_shifted[7:0]};
         2'b01:   load_data = {{16{~mem_funct3[2] & rdata_shifted[15]}}, rdata_shifted[15:0]};
         default: load_data = dmem_rdata;
      endcase
   end

   // WB register: a write is only qualified on the completion cycle, never for stores, misaligned ops or x0
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_wb          <= 5'd0;
         reg_file_wr_wb <= 1'b0;
         wb_data        <= 32'd0;
      end else begin
         rd_wb          <= mem_rd;
         wb_data        <= mem_mem_rd ? load_data : mem_alu_result;
         reg_file_wr_wb <= mem_valid & ~mem_stall & mem_reg_file_wr & ~mem_mem_wr
                           & ~addr_bad & (mem_rd != 5'd0);
      end
   end

   // Saturating count of stalled cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (mem_stall && (stall_cycles != {STALL_CNT_W{1'b1}})) begin
         stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Directed testbench for ex_mem_wb_pipe. A narrow stall counter makes saturation reachable.
module tb_ex_mem_wb_pipe;

   localparam int CNT_W = 2;

   logic             clk;
   logic             rst;
   logic             ex_valid;
   logic [4:0]       ex_rd;
   logic             ex_reg_file_wr;
   logic             ex_mem_rd;
   logic             ex_mem_wr;
   logic [2:0]       ex_funct3;
   logic [31:0]      ex_alu_result;
   logic [31:0]      ex_store_data;
   logic             dmem_ready;
   logic [31:0]      dmem_rdata;
   logic             dmem_req;
   logic             dmem_we;
   logic [31:0]      dmem_addr;
   logic [31:0]      dmem_wdata;
   logic [3:0]       dmem_be;
   logic             mem_stall;
   logic [4:0]       rd_mem;
   logic             reg_file_wr_mem;
   logic [31:0]      mem_fwd_data;
   logic             mem_is_load;
   logic [4:0]       rd_wb;
   logic             reg_file_wr_wb;
   logic [31:0]      wb_data;
   logic             misaligned;
   logic [CNT_W-1:0] stall_cycles;

   int checks = 0;
   int errors = 0;

   ex_mem_wb_pipe #(.STALL_CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_file_wr(ex_reg_file_wr),
      .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_funct3(ex_funct3),
      .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .mem_stall(mem_stall),
      .rd_mem(rd_mem), .reg_file_wr_mem(reg_file_wr_mem), .mem_fwd_data(mem_fwd_data),
      .mem_is_load(mem_is_load), .rd_wb(rd_wb), .reg_file_wr_wb(reg_file_wr_wb),
      .wb_data(wb_data), .misaligned(misaligned), .stall_cycles(stall_cycles)
   );

   // 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Absolute time limit so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] time limit reached");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic wr,
                                input logic mrd, input logic mwr, input logic [2:0] f3,
                                input logic [31:0] alu, input logic [31:0] sd);
      ex_valid       = v;
      ex_rd          = rd;
      ex_reg_file_wr = wr;
      ex_mem_rd      = mrd;
      ex_mem_wr      = mwr;
      ex_funct3      = f3;
      ex_alu_result  = alu;
      ex_store_data  = sd;
   endtask

   task automatic bubble();
      applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      rst        = 1'b1;
      dmem_ready = 1'b0;
      dmem_rdata = 32'd0;
      bubble();
      tick();
      tick();

      $display("[TB] reset state");
      checkOutput("rst_req",     32'(dmem_req), 32'd0);
      checkOutput("rst_stall",   32'(mem_stall), 32'd0);
      checkOutput("rst_wr_mem",  32'(reg_file_wr_mem), 32'd0);
      checkOutput("rst_wr_wb",   32'(reg_file_wr_wb), 32'd0);
      checkOutput("rst_misal",   32'(misaligned), 32'd0);
      checkOutput("rst_cnt",     32'(stall_cycles), 32'd0);
      checkOutput("rst_addr",    dmem_addr, 32'd0);
      checkOutput("rst_wdata",   dmem_wdata, 32'd0);
      checkOutput("rst_be",      32'(dmem_be), 32'd0);
      checkOutput("rst_wbdata",  wb_data, 32'd0);
      checkOutput("rst_fwd",     mem_fwd_data, 32'd0);
      rst = 1'b0;

      $display("[TB] ALU op, zero wait");
      dmem_ready = 1'b1;
      applyStimulus(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 3'd0, 32'h1234, 32'd0);
      tick();
      bubble();
      checkOutput("alu_rd_mem",  32'(rd_mem), 32'd5);
      checkOutput("alu_wr_mem",  32'(reg_file_wr_mem), 32'd1);
      checkOutput("alu_fwd",     mem_fwd_data, 32'h1234);
      checkOutput("alu_req",     32'(dmem_req), 32'd0);
      tick();
      checkOutput("alu_rd_wb",   32'(rd_wb), 32'd5);
      checkOutput("alu_wr_wb",   32'(reg_file_wr_wb), 32'd1);
      checkOutput("alu_wb_data", wb_data, 32'h1234);

      $display("[TB] LB with three wait cycles");
      dmem_ready = 1'b0;
      applyStimulus(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 32'd0);
      tick();
      bubble();
      checkOutput("lb_req",      32'(dmem_req), 32'd1);
      checkOutput("lb_we",       32'(dmem_we), 32'd0);
      checkOutput("lb_addr",     dmem_addr, 32'h100);
      checkOutput("lb_be",       32'(dmem_be), 32'b1000);
      checkOutput("lb_stall1",   32'(mem_stall), 32'd1);
      checkOutput("lb_is_load",  32'(mem_is_load), 32'd1);
      tick();
      checkOutput("lb_stall2",   32'(mem_stall), 32'd1);
      checkOutput("lb_cnt1",     32'(stall_cycles), 32'd1);
      checkOutput("lb_wb_bub",   32'(reg_file_wr_wb), 32'd0);
      tick();
      checkOutput("lb_stall3",   32'(mem_stall), 32'd1);
      checkOutput("lb_cnt2",     32'(stall_cycles), 32'd2);
      checkOutput("lb_hold_addr", dmem_addr, 32'h100);
      checkOutput("lb_wb_bub2",  32'(reg_file_wr_wb), 32'd0);
      tick();
      dmem_ready = 1'b1;
      dmem_rdata = 32'h80FFFFFF;
      #1;
      checkOutput("lb_cnt3",     32'(stall_cycles), 32'd3);
      checkOutput("lb_req_done", 32'(dmem_req), 32'd1);
      checkOutput("lb_nostall",  32'(mem_stall), 32'd0);
      tick();
      checkOutput("lb_rd_wb",    32'(rd_wb), 32'd7);
      checkOutput("lb_wr_wb",    32'(reg_file_wr_wb), 32'd1);
      checkOutput("lb_wb_data",  wb_data, 32'hFFFFFF80);
      checkOutput("lb_req_off",  32'(dmem_req), 32'd0);
      checkOutput("lb_cnt_hold", 32'(stall_cycles), 32'd3);

      $display("[TB] SH zero wait, write-enable set on a store");
      applyStimulus(1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD);
      tick();
      bubble();
      checkOutput("sh_req",      32'(dmem_req), 32'd1);
      checkOutput("sh_we",       32'(dmem_we), 32'd1);
      checkOutput("sh_be",       32'(dmem_be), 32'b1100);
      checkOutput("sh_wdata",    dmem_wdata, 32'hABCDABCD);
      checkOutput("sh_addr",     dmem_addr, 32'h100);
      checkOutput("sh_stall",    32'(mem_stall), 32'd0);
      tick();
      checkOutput("sh_wr_wb",    32'(reg_file_wr_wb), 32'd0);

      $display("[TB] SB and LHU byte lanes");
      applyStimulus(1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h201, 32'h12345655);
      tick();
      checkOutput("sb_be",       32'(dmem_be), 32'b0010);
      checkOutput("sb_wdata",    dmem_wdata, 32'h55555555);
      dmem_rdata = 32'h87654321;
      applyStimulus(1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 3'b101, 32'h102, 32'd0);
      tick();
      bubble();
      checkOutput("lhu_be",      32'(dmem_be), 32'b1100);
      tick();
      checkOutput("lhu_rd_wb",   32'(rd_wb), 32'd6);
      checkOutput("lhu_wr_wb",   32'(reg_file_wr_wb), 32'd1);
      checkOutput("lhu_wb_data", wb_data, 32'h00008765);

      $display("[TB] misaligned LW");
      dmem_ready = 1'b0;
      applyStimulus(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 3'b010, 32'h101, 32'd0);
      tick();
      bubble();
      checkOutput("mis_req",     32'(dmem_req), 32'd0);
      checkOutput("mis_pulse",   32'(misaligned), 32'd1);
      checkOutput("mis_stall",   32'(mem_stall), 32'd0);
      tick();
      checkOutput("mis_pulse_end", 32'(misaligned), 32'd0);
      checkOutput("mis_wr_wb",   32'(reg_file_wr_wb), 32'd0);

      $display("[TB] ALU op to x0");
      applyStimulus(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0, 32'hDEAD, 32'd0);
      tick();
      bubble();
      checkOutput("x0_wr_mem",   32'(reg_file_wr_mem), 32'd1);
      checkOutput("x0_fwd",      mem_fwd_data, 32'hDEAD);
      tick();
      checkOutput("x0_wr_wb",    32'(reg_file_wr_wb), 32'd0);

      $display("[TB] reset during WAIT");
      applyStimulus(1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010, 32'h200, 32'd0);
      tick();
      bubble();
      checkOutput("rw_req",      32'(dmem_req), 32'd1);
      tick();
      checkOutput("rw_cnt_sat",  32'(stall_cycles), 32'd3);
      checkOutput("rw_wait_req", 32'(dmem_req), 32'd1);
      checkOutput("rw_addr",     dmem_addr, 32'h200);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rw_req_off",  32'(dmem_req), 32'd0);
      checkOutput("rw_stall",    32'(mem_stall), 32'd0);
      checkOutput("rw_cnt",      32'(stall_cycles), 32'd0);
      checkOutput("rw_wr_wb0",   32'(reg_file_wr_wb), 32'd0);
      dmem_ready = 1'b1;
      tick();
      checkOutput("rw_wr_wb1",   32'(reg_file_wr_wb), 32'd0);
      checkOutput("rw_req_idle", 32'(dmem_req), 32'd0);
      tick();
      checkOutput("rw_wr_wb2",   32'(reg_file_wr_wb), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
